// File: rtl/counter_timer_arbiter_if.sv
// Requester-side bundle of the shared counter timer: requests, delays, hold/cancel
// controls and the grant/done/busy responses.
interface counter_timer_arbiter_if;
  logic [1:0] req;
  logic [3:0] delay0;
  logic [3:0] delay1;
  logic       hold;
  logic       cancel;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;

  modport master (
    output req, delay0, delay1, hold, cancel,
    input  grant, done, busy
  );

  modport slave (
    input  req, delay0, delay1, hold, cancel,
    output grant, done, busy
  );
endinterface

// File: rtl/counter_timer_arbiter.sv
// Round-robin owner of a shared 4-bit up-counter used as a delay timer by two
// requesters; preloads the counter so its carry fires after the requested ticks.
module counter_timer_arbiter #(
  parameter int CNT_W     = 4,
  parameter int FIRST_PRI = 0
) (
  input  logic                   clk,
  input  logic                   clear,
  counter_timer_arbiter_if.slave bus,
  output logic                   cnt_load,
  output logic                   cnt_count,
  output logic [CNT_W-1:0]       cnt_data,
  output logic                   cnt_clear_b,
  input  logic                   cnt_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic PTR_INIT = (FIRST_PRI != 0) ? 1'b1 : 1'b0;

  state_t     state_r;
  logic       owner_r;
  logic       ptr_r;
  logic [1:0] grant_r;
  logic [1:0] done_r;
  logic       busy_r;
  logic       load_r;
  logic [3:0] data_r;

  logic       win_s;
  logic [3:0] win_delay_s;
  logic       count_s;
  logic       expire_s;

  // A delay of d ticks needs the counter to start at 16-d; d=0 wraps to a full 16.
  function automatic logic [3:0] preload_f(input logic [3:0] d);
    preload_f = 4'd0 - d;
  endfunction

  function automatic logic [1:0] onehot_f(input logic idx);
    onehot_f = idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin winner and its delay, evaluated every cycle but only used in IDLE.
  always_comb begin
    win_s       = ptr_r;
    win_delay_s = bus.delay0;
    if (bus.req[ptr_r]) begin
      win_s = ptr_r;
    end else begin
      win_s = ~ptr_r;
    end
    if (win_s) begin
      win_delay_s = bus.delay1;
    end else begin
      win_delay_s = bus.delay0;
    end
  end

  // Counter enable; carry-out is only trusted while the counter is enabled.
  always_comb begin
    count_s  = 1'b0;
    expire_s = 1'b0;
    if (state_r == RUN) begin
      count_s = ~bus.hold & ~bus.cancel;
    end else begin
      count_s = 1'b0;
    end
    expire_s = count_s & cnt_cout;
  end

  // Arbitration / timer sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      ptr_r   <= PTR_INIT;
      grant_r <= 2'b00;
      done_r  <= 2'b00;
      busy_r  <= 1'b0;
      load_r  <= 1'b0;
      data_r  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.req) begin
            owner_r <= win_s;
            grant_r <= onehot_f(win_s);
            busy_r  <= 1'b1;
            load_r  <= 1'b1;
            data_r  <= preload_f(win_delay_s);
            state_r <= LOAD;
          end
        end
        LOAD: begin
          load_r  <= 1'b0;
          data_r  <= 4'd0;
          state_r <= RUN;
        end
        RUN: begin
          // Cancel beats a simultaneous expiry and still hands priority over.
          if (bus.cancel) begin
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
            ptr_r   <= ~owner_r;
            state_r <= IDLE;
          end else if (expire_s) begin
            done_r  <= onehot_f(owner_r);
            state_r <= DONE;
          end
        end
        DONE: begin
          done_r  <= 2'b00;
          grant_r <= 2'b00;
          busy_r  <= 1'b0;
          ptr_r   <= ~owner_r;
          state_r <= IDLE;
        end
        default: begin
          grant_r <= 2'b00;
          done_r  <= 2'b00;
          busy_r  <= 1'b0;
          load_r  <= 1'b0;
          data_r  <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign cnt_load    = load_r;
  assign cnt_data    = data_r;
  assign cnt_count   = count_s;
  assign cnt_clear_b = ~clear;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Scoreboard bench: the driver predicts each transaction from the round-robin and
// tick-count rules; a negedge monitor pops and checks the DUT's responses.
module tb_counter_timer_arbiter;
  localparam int FIRST_PRI = 0;
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_GONE = 3, P_CLR = 4;

  typedef struct {
    int         w;
    logic [3:0] pre;
    int         ticks;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       cnt_load, cnt_count, cnt_clear_b, cnt_cout;
  logic [3:0] cnt_data;
  logic [3:0] cval;

  counter_timer_arbiter_if bus();

  counter_timer_arbiter #(.CNT_W(4), .FIRST_PRI(FIRST_PRI)) dut (
    .clk(clk), .clear(clear), .bus(bus),
    .cnt_load(cnt_load), .cnt_count(cnt_count), .cnt_data(cnt_data),
    .cnt_clear_b(cnt_clear_b), .cnt_cout(cnt_cout)
  );

  always #5 clk = ~clk;

  // Model of the external parallel-load up-counter.
  always @(posedge clk or negedge cnt_clear_b) begin
    if (!cnt_clear_b) cval <= 4'd0;
    else if (cnt_load) cval <= cnt_data;
    else if (cnt_count) cval <= cval + 4'd1;
  end
  assign cnt_cout = cnt_count && (cval == 4'hF);

  int   n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  int   ptr_m;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: phase tracking from the spec's latency rules, not the DUT state.
  int   ph = P_CLR;
  exp_t cur;
  int   ticks;
  always @(negedge clk) begin
    if (mon_en) begin
      case (ph)
        P_IDLE: begin
          chk("idle_done", bus.done, 2'b00);
          if (cnt_load) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_load", 1, 0);
              cur.w = 0; cur.pre = 4'd0; cur.ticks = 16;
            end else begin
              cur = exp_q.pop_front();
            end
            chk("load_grant", bus.grant, (cur.w == 1) ? 2'b10 : 2'b01);
            chk("load_data", cnt_data, cur.pre);
            chk("load_busy", bus.busy, 1'b1);
            chk("load_count", cnt_count, 1'b0);
            ticks = 0;
            ph    = P_RUN;
          end else begin
            chk("idle_grant", bus.grant, 2'b00);
            chk("idle_busy", bus.busy, 1'b0);
          end
        end
        P_RUN: begin
          chk("run_done", bus.done, 2'b00);
          chk("run_grant", bus.grant, (cur.w == 1) ? 2'b10 : 2'b01);
          chk("run_load", cnt_load, 1'b0);
          chk("run_count", cnt_count, !bus.hold && !bus.cancel);
          if (!clear) chk("run_cval", cval, cur.pre + 4'(ticks));
          if (bus.cancel) ph = P_GONE;
          else if (!bus.hold) begin
            ticks++;
            if (ticks == cur.ticks) ph = P_DONE;
          end
        end
        P_DONE: begin
          chk("done_pulse", bus.done, (cur.w == 1) ? 2'b10 : 2'b01);
          chk("done_grant", bus.grant, (cur.w == 1) ? 2'b10 : 2'b01);
          chk("done_count", cnt_count, 1'b0);
          ph = P_IDLE;
        end
        P_GONE: begin
          chk("cancel_grant", bus.grant, 2'b00);
          chk("cancel_done", bus.done, 2'b00);
          chk("cancel_busy", bus.busy, 1'b0);
          ph = P_IDLE;
        end
        default: begin
          chk("rst_grant", bus.grant, 2'b00);
          chk("rst_done", bus.done, 2'b00);
          chk("rst_busy", bus.busy, 1'b0);
          chk("rst_load", cnt_load, 1'b0);
          chk("rst_data", cnt_data, 4'd0);
          chk("rst_count", cnt_count, 1'b0);
          ph = P_IDLE;
        end
      endcase
      chk("clear_b", cnt_clear_b, !clear);
      if (clear) ph = P_CLR;
    end
  end

  task automatic do_reset();
    bus.req = 2'b00;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ptr_m = FIRST_PRI;
  endtask

  task automatic run_txn(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [63:0] hmask, input int cancel_at, input int clear_at,
                         input bit drop);
    exp_t e;
    int   d;
    bit   got_load = 1'b0, fin = 1'b0, cleared = 1'b0;
    e.w     = r[ptr_m] ? ptr_m : 1 - ptr_m;
    d       = (e.w == 1) ? int'(d1) : int'(d0);
    e.ticks = (d == 0) ? 16 : d;
    e.pre   = 4'(16 - e.ticks);
    exp_q.push_back(e);
    bus.req = r; bus.delay0 = d0; bus.delay1 = d1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.hold = 1'b0; bus.cancel = 1'b0;
      @(negedge clk);
      if (cnt_load) begin got_load = 1'b1; break; end
    end
    if (!got_load) begin
      chk("load_timeout", 0, 1);
      return;
    end
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      bus.hold   = hmask[k];
      bus.cancel = (k == cancel_at);
      clear      = (k == clear_at);
      if (k == clear_at) cleared = 1'b1;
      if (k == 1) begin
        bus.delay0 = 4'($urandom);
        bus.delay1 = 4'($urandom);
        if (drop) bus.req = 2'b00;
      end
      @(negedge clk);
      if (bus.done != 2'b00 || !bus.busy) begin fin = 1'b1; break; end
    end
    if (!fin) chk("run_timeout", 0, 1);
    if (clear) begin
      @(posedge clk); #1;
      clear = 1'b0;
    end
    ptr_m = cleared ? FIRST_PRI : 1 - e.w;
  endtask

  initial begin
    clear = 1'b1;
    bus.req = 2'b00; bus.delay0 = 4'd0; bus.delay1 = 4'd0;
    bus.hold = 1'b0; bus.cancel = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ptr_m = FIRST_PRI;

    run_txn(2'b01, 4'd3, 4'd0, 64'd0, 0, 0, 1'b1);
    do_reset();
    run_txn(2'b11, 4'd2, 4'd5, 64'd0, 0, 0, 1'b0);
    run_txn(2'b11, 4'd2, 4'd5, 64'd0, 0, 0, 1'b0);
    run_txn(2'b11, 4'd2, 4'd5, 64'd0, 0, 0, 1'b0);
    run_txn(2'b10, 4'd9, 4'd0, 64'd0, 0, 0, 1'b0);
    run_txn(2'b01, 4'd4, 4'd0, 64'h1C, 0, 0, 1'b0);
    run_txn(2'b01, 4'd6, 4'd0, 64'd0, 2, 0, 1'b0);
    run_txn(2'b11, 4'd1, 4'd1, 64'd0, 0, 0, 1'b0);
    run_txn(2'b11, 4'd7, 4'd7, 64'd0, 0, 3, 1'b0);
    run_txn(2'b11, 4'd2, 4'd2, 64'd0, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] hm;
      int ca, cl;
      hm = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 18)) : 0;
      cl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 18)) : 0;
      run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), hm, ca, cl,
              1'($urandom_range(0, 1)));
    end

    bus.req = 2'b00; bus.hold = 1'b0; bus.cancel = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
